// File: rtl/mips_mem_port.sv
//==============================================================================
// mips_mem_port : converts controller read/write strobes into a req/ack
//                 memory transaction with timeout and misalignment reporting
// Revision      : 1.0
//==============================================================================
`default_nettype none

module mips_mem_port #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_busy_q,  cpu_busy_d;
  logic              cpu_done_q,  cpu_done_d;
  logic              cpu_err_q,   cpu_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      cpu_busy_q  <= 1'b0;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_busy_q  <= cpu_busy_d;
      cpu_done_q  <= cpu_done_d;
      cpu_err_q   <= cpu_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_busy_d  = cpu_busy_q;
    cpu_done_d  = 1'b0;
    cpu_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cpu_busy_d = 1'b0;
        if (cpu_rd || cpu_wr) begin
          if (cpu_addr[1:0] != 2'b00) begin
            // Misaligned: fail immediately without touching memory
            cpu_done_d = 1'b1;
            cpu_err_d  = 1'b1;
          end else begin
            state_d     = ST_WAIT;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = cpu_wr;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            cpu_busy_d  = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (mem_ack) begin
          state_d    = ST_IDLE;
          cpu_busy_d = 1'b0;
          cpu_done_d = 1'b1;
          if (!mem_we_q) begin
            cpu_rdata_d = mem_rdata;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d    = ST_IDLE;
          cpu_busy_d = 1'b0;
          cpu_done_d = 1'b1;
          cpu_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        cpu_busy_d = 1'b0;
      end
    endcase
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_busy  = cpu_busy_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_err   = cpu_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_port.sv
//==============================================================================
// tb_mips_mem_port : self-checking bench for mips_mem_port
// Revision         : 1.0
//==============================================================================
`default_nettype none

module tb_mips_mem_port;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_busy, cpu_done, cpu_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] rdata_model = 32'h0;

  always #5 clk = ~clk;

  mips_mem_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Drives one request and records what the port did; the memory answers
  // `lat` cycles after the mem_req cycle (never, if lat >= TIMEOUT).
  // done_edge counts clock edges from the point the request is presented.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input logic [31:0] rdv,
                         output int done_edge, output logic err, output int req_cnt,
                         output logic hold_ok);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    done_edge = -1; err = 1'b0; req_cnt = 0; hold_ok = 1'b1;
    for (int c = 0; c < TIMEOUT + 8; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
      if (mem_req === 1'b1) req_cnt++;
      if (cpu_done === 1'b1) begin
        done_edge = c + 1;
        err = cpu_err;
        if (cpu_busy !== 1'b0) hold_ok = 1'b0;
        break;
      end
      if (cpu_busy !== 1'b1 || mem_addr !== addr || mem_wdata !== wdata || mem_we !== wr)
        hold_ok = 1'b0;
      mem_ack   = (c == lat);
      mem_rdata = (c == lat) ? rdv : $urandom();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    logic [135:0] all_out;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    all_out = {cpu_rdata, cpu_busy, cpu_done, cpu_err, mem_req, mem_we, mem_addr, mem_wdata, 3'b000};
    checks++;
    if (all_out !== '0) $display("FAIL reset_outputs: got %h, want 0", all_out);
    else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({cpu_done, cpu_busy, mem_req} !== 3'b000)
      $display("FAIL idle_after_reset: done/busy/req=%b, want 000", {cpu_done, cpu_busy, mem_req});
    else passes++;
  endtask

  task automatic test_read_zero_latency;
    int de, rc; logic er, ho;
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hCAFEF00D, de, er, rc, ho);
    rdata_model = 32'hCAFEF00D;
    checks++; if (de !== 2) $display("FAIL rd0_latency: got %0d, want 2", de); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL rd0_err: got %b, want 0", er); else passes++;
    checks++; if (cpu_rdata !== rdata_model) $display("FAIL rd0_rdata: got %h, want %h", cpu_rdata, rdata_model); else passes++;
    checks++; if (rc !== 1) $display("FAIL rd0_reqs: got %0d, want 1", rc); else passes++;
    @(posedge clk); #1;
    checks++; if (cpu_done !== 1'b0) $display("FAIL rd0_done_pulse: got %b, want 0", cpu_done); else passes++;
  endtask

  task automatic test_write_latency5;
    int de, rc; logic er, ho;
    run_txn(1'b0, 1'b1, 32'h20, 32'h12345678, 5, 32'hBAADBEEF, de, er, rc, ho);
    checks++; if (de !== 7) $display("FAIL wr5_latency: got %0d, want 7", de); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL wr5_err: got %b, want 0", er); else passes++;
    checks++; if (rc !== 1) $display("FAIL wr5_reqs: got %0d, want 1", rc); else passes++;
    checks++; if (ho !== 1'b1) $display("FAIL wr5_hold: got %b, want 1", ho); else passes++;
    checks++; if (cpu_rdata !== rdata_model) $display("FAIL wr5_rdata: got %h, want %h", cpu_rdata, rdata_model); else passes++;
  endtask

  task automatic test_timeout;
    int de, rc; logic er, ho;
    run_txn(1'b1, 1'b0, 32'h40, 32'h0, TIMEOUT + 4, 32'h11111111, de, er, rc, ho);
    checks++; if (de !== TIMEOUT + 1) $display("FAIL tmo_latency: got %0d, want %0d", de, TIMEOUT + 1); else passes++;
    checks++; if (er !== 1'b1) $display("FAIL tmo_err: got %b, want 1", er); else passes++;
    mem_ack = 1'b1; mem_rdata = 32'hDEADDEAD;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ({cpu_done, cpu_busy, mem_req} !== 3'b000 || cpu_rdata !== rdata_model)
        $display("FAIL tmo_late_ack: done/busy/req=%b rdata=%h, want 000 rdata=%h",
                 {cpu_done, cpu_busy, mem_req}, cpu_rdata, rdata_model);
      else passes++;
    end
    mem_ack = 1'b0;
    // Ack in the final allowed cycle must still succeed
    run_txn(1'b1, 1'b0, 32'h44, 32'h0, TIMEOUT - 1, 32'h5A5A5A5A, de, er, rc, ho);
    rdata_model = 32'h5A5A5A5A;
    checks++; if (de !== TIMEOUT + 1 || er !== 1'b0) $display("FAIL tmo_edge_ack: edge=%0d err=%b, want %0d 0", de, er, TIMEOUT + 1); else passes++;
    checks++; if (cpu_rdata !== rdata_model) $display("FAIL tmo_after_read: got %h, want %h", cpu_rdata, rdata_model); else passes++;
  endtask

  task automatic test_misaligned_contention;
    int de, rc, reqs; logic er, ho;
    run_txn(1'b1, 1'b0, 32'h13, 32'h0, 0, 32'h77777777, de, er, rc, ho);
    checks++; if (de !== 1 || er !== 1'b1) $display("FAIL mis_done: edge=%0d err=%b, want 1 1", de, er); else passes++;
    checks++; if (rc !== 0) $display("FAIL mis_reqs: got %0d, want 0", rc); else passes++;
    checks++; if (cpu_rdata !== rdata_model) $display("FAIL mis_rdata: got %h, want %h", cpu_rdata, rdata_model); else passes++;
    run_txn(1'b1, 1'b1, 32'h60, 32'hA5A5A5A5, 2, 32'h99999999, de, er, rc, ho);
    checks++; if (ho !== 1'b1 || er !== 1'b0 || de !== 4) $display("FAIL both_write_wins: hold=%b err=%b edge=%0d, want 1 0 4", ho, er, de); else passes++;
    checks++; if (cpu_rdata !== rdata_model) $display("FAIL both_rdata: got %h, want %h", cpu_rdata, rdata_model); else passes++;
    // Hold cpu_rd high through the whole WAIT: only one request may be issued
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h80; reqs = 0; de = -1;
    for (int c = 0; c < TIMEOUT + 8; c++) begin
      @(posedge clk); #1;
      if (mem_req === 1'b1) reqs++;
      if (cpu_done === 1'b1) begin de = c + 1; break; end
      if (c == 3) begin mem_ack = 1'b1; mem_rdata = 32'h0BADF00D; cpu_rd = 1'b0; end
    end
    mem_ack = 1'b0; cpu_rd = 1'b0;
    rdata_model = 32'h0BADF00D;
    checks++; if (reqs !== 1) $display("FAIL busy_drop_reqs: got %0d, want 1", reqs); else passes++;
    checks++; if (de !== 5 || cpu_rdata !== rdata_model) $display("FAIL busy_drop_done: edge=%0d rdata=%h, want 5 %h", de, cpu_rdata, rdata_model); else passes++;
  endtask

  task automatic test_reset_back_to_back;
    int de, rc; logic er, ho;
    logic [135:0] all_out;
    cpu_rd = 1'b1; cpu_addr = 32'h30;
    @(posedge clk); #1; cpu_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rdata_model = 32'h0;
    all_out = {cpu_rdata, cpu_busy, cpu_done, cpu_err, mem_req, mem_we, mem_addr, mem_wdata, 3'b000};
    checks++; if (all_out !== '0) $display("FAIL midwait_reset: got %h, want 0", all_out); else passes++;
    mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (cpu_done !== 1'b0 || cpu_rdata !== rdata_model)
        $display("FAIL post_reset_ack: done=%b rdata=%h, want 0 %h", cpu_done, cpu_rdata, rdata_model);
      else passes++;
    end
    mem_ack = 1'b0;
    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hAAAA0001, de, er, rc, ho);
    checks++; if (de !== 3 || cpu_rdata !== 32'hAAAA0001) $display("FAIL b2b_first: edge=%0d rdata=%h, want 3 aaaa0001", de, cpu_rdata); else passes++;
    run_txn(1'b1, 1'b0, 32'h104, 32'h0, 0, 32'hBBBB0002, de, er, rc, ho);
    rdata_model = 32'hBBBB0002;
    checks++; if (de !== 2 || rc !== 1 || cpu_rdata !== rdata_model) $display("FAIL b2b_second: edge=%0d reqs=%0d rdata=%h, want 2 1 %h", de, rc, cpu_rdata, rdata_model); else passes++;
  endtask

  task automatic test_random;
    int de, rc, lat, exp_edge, exp_req, gap;
    logic er, ho, rd, wr, mis, tmo, exp_err;
    logic [1:0]  kind;
    logic [31:0] a, wd, rdv;
    for (int n = 0; n < 30; n++) begin
      kind = 2'($urandom_range(1, 3));
      rd = kind[0]; wr = kind[1];
      a = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wd = $urandom(); rdv = $urandom();
      lat = $urandom_range(0, TIMEOUT + 2);
      run_txn(rd, wr, a, wd, lat, rdv, de, er, rc, ho);
      mis = (a[1:0] != 2'b00);
      tmo = !mis && (lat >= TIMEOUT);
      exp_err  = mis || tmo;
      exp_req  = mis ? 0 : 1;
      exp_edge = mis ? 1 : (tmo ? TIMEOUT + 1 : lat + 2);
      if (!mis && !tmo && !wr) rdata_model = rdv;
      checks++; if (de !== exp_edge) $display("FAIL rnd%0d_latency: got %0d, want %0d", n, de, exp_edge); else passes++;
      checks++; if (er !== exp_err) $display("FAIL rnd%0d_err: got %b, want %b", n, er, exp_err); else passes++;
      checks++; if (rc !== exp_req) $display("FAIL rnd%0d_reqs: got %0d, want %0d", n, rc, exp_req); else passes++;
      checks++; if (ho !== 1'b1) $display("FAIL rnd%0d_hold: got %b, want 1", n, ho); else passes++;
      checks++; if (cpu_rdata !== rdata_model) $display("FAIL rnd%0d_rdata: got %h, want %h", n, cpu_rdata, rdata_model); else passes++;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_read_zero_latency();
    test_write_latency5();
    test_timeout();
    test_misaligned_contention();
    test_reset_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
